// File: rtl/instruction_pkg.sv
// Shared definitions for the instruction loader: FSM encoding,
// default geometry and a byte-insert helper.
`timescale 1ns/1ps
package instruction_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [31:0] put_byte(
    input logic [31:0] word,
    input logic [1:0]  slot,
    input logic [7:0]  data
  );
    logic [31:0] r;
    r = word;
    r[{slot, 3'b000} +: 8] = data;
    return r;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word.
// Slots not yet written stay zero because clear zeroes the word.
`timescale 1ns/1ps
module byte_packer
  import instruction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_lastSlot
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_load) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= put_byte(r_word, r_idx, i_byte);
    end
  end

  assign o_word     = r_word;
  assign o_lastSlot = (r_idx == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Streams program bytes into instruction memory one word at a time,
// holding the processor off memory while a load is in progress.
`timescale 1ns/1ps
module instruction_loader
  import instruction_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  input  logic              byteLast,
  output logic              byteReady,
  output logic              writeEnable,
  output logic [31:0]       writeAddress,
  output logic [31:0]       writeData,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wordCount
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_lastSeen;

  logic              w_recv;
  logic              w_write;
  logic              w_accept;
  logic              w_wordEnd;
  logic              w_startLoad;
  logic              w_clear;
  logic              w_lastSlot;
  logic              w_atTop;
  logic [31:0]       w_word;

  assign w_recv      = (r_state == S_RECV);
  assign w_write     = (r_state == S_WRITE);
  assign w_accept    = w_recv & byteValid;
  assign w_wordEnd   = w_accept & (byteLast | w_lastSlot);
  assign w_startLoad = (r_state == S_IDLE) & start;
  assign w_clear     = w_startLoad | w_write;
  assign w_atTop     = (r_index == LAST_IDX);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_load     (w_accept),
    .i_byte     (byteIn),
    .o_word     (w_word),
    .o_lastSlot (w_lastSlot)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RECV;
      S_RECV:  if (w_wordEnd) w_next = S_WRITE;
      S_WRITE: begin
        if (r_lastSeen || w_atTop) w_next = S_DONE;
        else w_next = S_RECV;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_lastSeen <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_startLoad) begin
        r_index    <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_lastSeen <= 1'b0;
      end
      if (w_accept && byteLast) r_lastSeen <= 1'b1;
      // the final slot saturates into overflow instead of wrapping
      if (w_write) begin
        r_count <= r_count + CNT_ONE;
        if (!r_lastSeen) begin
          if (w_atTop) r_overflow <= 1'b1;
          else r_index <= r_index + IDX_ONE;
        end
      end
    end
  end

  assign byteReady    = w_recv;
  assign writeEnable  = w_write;
  assign writeAddress = w_write ? 32'(r_index) : 32'd0;
  assign writeData    = w_write ? w_word : 32'd0;
  assign busy         = w_recv | w_write;
  assign done         = (r_state == S_DONE);
  assign overflow     = r_overflow;
  assign wordCount    = r_count;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit words in the instruction memory being loaded.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the internal word index (clog2(DEPTH)).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin a load; sampled only in IDLE.
REQ-007 byteIn  input  8  program byte, little-endian within each word.
REQ-008 byteValid  input  1  byteIn is valid.
REQ-009 byteLast  input  1  qualifies byteIn as the final byte of the program.
REQ-010 byteReady  output  1  loader accepts a byte this cycle.
REQ-011 writeEnable  output  1  one-cycle write strobe to the instruction memory write port.
REQ-012 writeAddress  output  32  word index being written, zero-extended, same word indexing as the memory read port.
REQ-013 writeData  output  32  assembled instruction word.
REQ-014 busy  output  1  load in progress; processor held off memory.
REQ-015 done  output  1  one-cycle pulse when a load completes.
REQ-016 overflow  output  1  last load exceeded DEPTH words; held until next start.
REQ-017 wordCount  output  ADDR_W+1  words written by the last load; held until next start.

Function
REQ-018 SHALL implement states IDLE, RECV, WRITE and DONE.
REQ-019 IDLE: byteReady=0; on start=1 SHALL clear the word index, byte index, assembly register, wordCount and overflow, then enter RECV.
REQ-020 RECV: byteReady=1; a byte transfers only when byteValid and byteReady are both 1 on a rising clock edge.
REQ-021 Byte k (k=0..3) of a word SHALL be stored in bits [8k+7:8k]; unfilled bytes SHALL be zero.
REQ-022 After the 4th byte, or any accepted byte with byteLast=1, SHALL enter WRITE on the next cycle.
REQ-023 WRITE: exactly one cycle with writeEnable=1, writeAddress=word index, writeData=assembled word; byteReady=0; wordCount increments.
REQ-024 From WRITE: if byteLast was accepted, go to DONE; else if word index = DEPTH-1, set overflow=1 and go to DONE; else increment the word index, clear the assembly register and return to RECV.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; busy=0.
REQ-026 busy SHALL be 1 exactly in RECV and WRITE.
REQ-027 start SHALL be ignored outside IDLE; byteValid and byteLast SHALL be ignored whenever byteReady=0.
REQ-028 writeEnable SHALL never be asserted outside WRITE, and SHALL never address an index >= DEPTH.
REQ-029 Peak throughput SHALL be one word per 5 cycles (4 byte transfers + 1 write); no combinational path from byteValid to byteReady.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and drive byteReady, writeEnable, busy, done and overflow to 0, and writeAddress, writeData and wordCount to 0.
REQ-031 rst asserted mid-load SHALL abort without a further write; the partial word is discarded.

Structure
REQ-032 State encoding, DEPTH and ADDR_W defaults SHALL reside in a shared package, instruction_pkg.
REQ-033 Byte-to-word assembly (byte index counter plus 32-bit shift/insert register) SHALL be a sub-module, byte_packer; the FSM and address counter stay in instruction_loader.

Verification
REQ-034 start, bytes 13,00,50,00 (last on 4th) -> single write addr 0, data 0x00500013; done pulse; wordCount=1.
REQ-035 start, 6 bytes 01..06 with last on 6th -> writes addr0=0x04030201, addr1=0x00000605; wordCount=2.
REQ-036 start, 33*4 bytes, no last -> 32 writes addr 0..31, overflow=1, byteReady=0 after the 32nd write, no write to addr 32.
REQ-037 byteValid toggled randomly during RECV plus start pulsed while busy -> data and addresses identical to the gap-free run; no restart.
REQ-038 rst asserted after 2 bytes of word 1 -> outputs 0 next edge, no write to addr 1; a new start then loads from addr 0.
